// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: line/beat geometry,
// cacheline offset width and the arbiter state encoding.
package mem_arb_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;

  // IDLE is encoded as zero so a cleared debug state reads as idle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_RD   = 3'd1,
    D_RD   = 3'd2,
    D_WR   = 3'd3,
    DONE_I = 3'd4,
    DONE_D = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_burst_buffer.sv
// Line buffer shared by every burst. It holds one cacheline and a beat
// counter. It can be loaded with a whole line, written one beat at a time
// at the counter, and read one beat at a time at the counter. o_last flags
// the final beat of a line.
module burst_buffer #(
  parameter int LINE_W  = mem_arb_pkg::LINE_W,
  parameter int BURST_W = mem_arb_pkg::BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [LINE_W-1:0]  i_load_line,
  input  logic               i_wr_beat,
  input  logic [BURST_W-1:0] i_beat_data,
  input  logic               i_step,
  input  logic               i_clear,
  output logic [LINE_W-1:0]  o_line,
  output logic [BURST_W-1:0] o_beat,
  output logic               o_last
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;

  // Line storage and beat counter. A load restarts the counter at beat 0.
  // A step on the last beat wraps the counter to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_line;
      r_cnt  <= '0;
    end else begin
      if (i_wr_beat) begin
        r_line[r_cnt*BURST_W +: BURST_W] <= i_beat_data;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_step) begin
        r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_last = (r_cnt == CNT_W'(BEATS - 1));
  assign o_beat = r_line[r_cnt*BURST_W +: BURST_W];
  assign o_line = r_line;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single burst memory port between the I-cache (read only)
// and the D-cache (read/write). The D-cache has fixed priority over the
// I-cache. Each 256-bit line moves as 4 64-bit beats, with beat 0 as the
// low word.
//
// Handshake: a cache raises read/write and holds it until its one-cycle
// resp pulse. mem_read/mem_write stay high for the whole burst. Each
// mem_resp cycle transfers exactly one beat. A mem_resp outside a burst
// is ignored.
module mem_arbiter #(
  parameter int LINE_W  = mem_arb_pkg::LINE_W,
  parameter int BURST_W = mem_arb_pkg::BURST_W,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic [2:0]         o_dbg_state
);

  import mem_arb_pkg::*;

  // Clears the line-offset bits so that every burst starts on a line boundary.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_grant_addr;
  logic               w_load;
  logic               w_wr_beat;
  logic               w_step;
  logic               w_clear;
  logic               w_last;
  logic [LINE_W-1:0]  w_line;
  logic [BURST_W-1:0] w_beat;

  // If the D-cache is requesting, its address is the one that gets granted.
  assign w_grant_addr = (d_write || d_read) ? d_addr : i_addr;

  burst_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_line (d_wdata),
    .i_wr_beat   (w_wr_beat),
    .i_beat_data (mem_rdata),
    .i_step      (w_step),
    .i_clear     (w_clear),
    .o_line      (w_line),
    .o_beat      (w_beat),
    .o_last      (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Line-aligned burst address, captured once per grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (w_load) begin
      r_addr <= w_grant_addr & ADDR_MASK;
    end
  end

  // Next-state logic and buffer control. The priority order is d_write,
  // then d_read, then i_read.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_wr_beat = 1'b0;
    w_step    = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_write) begin
          w_next = D_WR;
          w_load = 1'b1;
        end else if (d_read) begin
          w_next = D_RD;
          w_load = 1'b1;
        end else if (i_read) begin
          w_next = I_RD;
          w_load = 1'b1;
        end
      end
      I_RD, D_RD: begin
        if (mem_resp) begin
          w_wr_beat = 1'b1;
          w_step    = 1'b1;
          if (w_last) begin
            w_next = (r_state == I_RD) ? DONE_I : DONE_D;
          end
        end
      end
      D_WR: begin
        if (mem_resp) begin
          w_step = 1'b1;
          if (w_last) begin
            w_next = DONE_D;
          end
        end
      end
      DONE_I, DONE_D: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign mem_read    = (r_state == I_RD) || (r_state == D_RD);
  assign mem_write   = (r_state == D_WR);
  assign mem_addr    = r_addr;
  assign mem_wdata   = (r_state == D_WR) ? w_beat : '0;
  assign i_resp      = (r_state == DONE_I);
  assign d_resp      = (r_state == DONE_D);
  assign i_rdata     = w_line;
  assign d_rdata     = w_line;
  assign o_dbg_state = r_state;

endmodule
